dcache_resp_ctr: RTL and testbench

- Pipeline-side response handler for the data-cache access interface; the return path of the memory-stage request generator.
- Captures the attributes of each accepted request and holds the pipeline until the cache acknowledges.
- Extracts and sign/zero-extends load data, and produces SC.W results.
- Reports completion of stores, CACOP and IBAR, and supports flushes with a response still outstanding.

---
 rtl/dcache_resp_ctr.sv | 163 ++++++++++++++++
 tb/tb_dcache_resp_ctr.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_resp_ctr.sv
// Data-cache response handler: holds the memory stage until the cache acks, then
// formats load/SC.W results and signals completion of stores, CACOP and IBAR.
module dcache_resp_ctr #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    input  logic [3:0]  req_class,
    input  logic [4:0]  req_subtype,
    input  logic [1:0]  req_addr_lo,
    input  logic        llbit,
    input  logic        stall,
    input  logic        flush,
    input  logic        dcache_pipeline_ready,
    input  logic [31:0] dout_dcache_pipeline,
    output logic        stall_req,
    output logic        rd_valid,
    output logic        rd_we,
    output logic [31:0] rd_data,
    output logic        timeout_err
);

    localparam int unsigned   CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

    localparam logic [3:0] CLS_MEM  = 4'd5;
    localparam logic [3:0] CLS_ATOM = 4'd6;

    localparam logic [4:0] SUB_LDB  = 5'd0;
    localparam logic [4:0] SUB_LDH  = 5'd1;
    localparam logic [4:0] SUB_LDW  = 5'd2;
    localparam logic [4:0] SUB_LDBU = 5'd6;
    localparam logic [4:0] SUB_LDHU = 5'd7;
    localparam logic [4:0] SUB_LLW  = 5'd11;
    localparam logic [4:0] SUB_SCW  = 5'd12;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t        r_state;
    logic [3:0]    r_class;
    logic [4:0]    r_subtype;
    logic [1:0]    r_addr_lo;
    logic          r_llbit;
    logic          r_drop;
    logic [CW-1:0] r_cnt;
    logic          r_rd_valid;
    logic          r_rd_we;
    logic [31:0]   r_rd_data;
    logic          r_timeout;

    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_res_data;
    logic          w_res_we;

    always_comb begin
        w_byte = '0;
        case (r_addr_lo)
            2'd0: w_byte = dout_dcache_pipeline[7:0];
            2'd1: w_byte = dout_dcache_pipeline[15:8];
            2'd2: w_byte = dout_dcache_pipeline[23:16];
            2'd3: w_byte = dout_dcache_pipeline[31:24];
            default: w_byte = '0;
        endcase
        // Halfword lane comes from addr_lo[1] only; odd offsets are trapped upstream.
        w_half = r_addr_lo[1] ? dout_dcache_pipeline[31:16] : dout_dcache_pipeline[15:0];
    end

    always_comb begin
        w_res_data = '0;
        w_res_we   = 1'b0;
        if (r_class == CLS_MEM) begin
            case (r_subtype)
                SUB_LDB:  begin w_res_data = {{24{w_byte[7]}}, w_byte};  w_res_we = 1'b1; end
                SUB_LDBU: begin w_res_data = {24'b0, w_byte};            w_res_we = 1'b1; end
                SUB_LDH:  begin w_res_data = {{16{w_half[15]}}, w_half}; w_res_we = 1'b1; end
                SUB_LDHU: begin w_res_data = {16'b0, w_half};            w_res_we = 1'b1; end
                SUB_LDW:  begin w_res_data = dout_dcache_pipeline;       w_res_we = 1'b1; end
                default:  ;
            endcase
        end else if (r_class == CLS_ATOM) begin
            case (r_subtype)
                SUB_LLW: begin w_res_data = dout_dcache_pipeline; w_res_we = 1'b1; end
                SUB_SCW: begin w_res_data = {31'b0, r_llbit};     w_res_we = 1'b1; end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_class    <= '0;
            r_subtype  <= '0;
            r_addr_lo  <= '0;
            r_llbit    <= 1'b0;
            r_drop     <= 1'b0;
            r_cnt      <= '0;
            r_rd_valid <= 1'b0;
            r_rd_we    <= 1'b0;
            r_rd_data  <= '0;
            r_timeout  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid && !flush) begin
                        r_class   <= req_class;
                        r_subtype <= req_subtype;
                        r_addr_lo <= req_addr_lo;
                        r_llbit   <= llbit;
                        r_state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (flush) begin
                        r_drop <= 1'b1;
                    end
                    if (dcache_pipeline_ready) begin
                        // A flush coinciding with the ack discards the result as well.
                        if (r_drop || flush) begin
                            r_state <= S_IDLE;
                            r_drop  <= 1'b0;
                            r_cnt   <= '0;
                        end else begin
                            r_state    <= S_HOLD;
                            r_rd_valid <= 1'b1;
                            r_rd_we    <= w_res_we;
                            r_rd_data  <= w_res_data;
                        end
                    end else if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == CNT_MAX - 1'b1) begin
                            r_timeout <= 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (flush || !stall) begin
                        r_state    <= S_IDLE;
                        r_rd_valid <= 1'b0;
                        r_drop     <= 1'b0;
                        r_cnt      <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign stall_req   = ((r_state == S_IDLE) & req_valid & ~flush)
                       | (r_state == S_WAIT)
                       | ((r_state == S_HOLD) & stall);
    assign rd_valid    = r_rd_valid;
    assign rd_we       = r_rd_we;
    assign rd_data     = r_rd_data;
    assign timeout_err = r_timeout;

endmodule

// File: tb/tb_dcache_resp_ctr.sv
// Scoreboard bench for dcache_resp_ctr: expected results are queued as requests are
// issued and popped when rd_valid appears.
module tb_dcache_resp_ctr;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0;
    logic [3:0]  req_class = '0;
    logic [4:0]  req_subtype = '0;
    logic [1:0]  req_addr_lo = '0;
    logic        llbit = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        dready = 1'b0;
    logic [31:0] dout = '0;
    logic        stall_req;
    logic        rd_valid;
    logic        rd_we;
    logic [31:0] rd_data;
    logic        timeout_err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] d;
        logic        we;
    } exp_t;

    typedef struct {
        logic [3:0]  c;
        logic [4:0]  s;
        logic [1:0]  a;
        logic        ll;
        logic [31:0] w;
        int          lat;
        logic [31:0] ed;
        logic        ew;
    } vec_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    dcache_resp_ctr #(.TIMEOUT(1023)) dut (
        .clk                   (clk),
        .rstn                  (rstn),
        .req_valid             (req_valid),
        .req_class             (req_class),
        .req_subtype           (req_subtype),
        .req_addr_lo           (req_addr_lo),
        .llbit                 (llbit),
        .stall                 (stall),
        .flush                 (flush),
        .dcache_pipeline_ready (dready),
        .dout_dcache_pipeline  (dout),
        .stall_req             (stall_req),
        .rd_valid              (rd_valid),
        .rd_we                 (rd_we),
        .rd_data               (rd_data),
        .timeout_err           (timeout_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [3:0] c, input logic [4:0] s,
                             input logic [1:0] a, input logic ll);
        req_valid   = 1'b1;
        req_class   = c;
        req_subtype = s;
        req_addr_lo = a;
        llbit       = ll;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset rd_valid: got %b want 0", rd_valid); end
        checks++; if (rd_we !== 1'b0) begin errors++; $display("FAIL reset rd_we: got %b want 0", rd_we); end
        checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL reset rd_data: got %h want 0", rd_data); end
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL reset stall_req: got %b want 0", stall_req); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset timeout_err: got %b want 0", timeout_err); end
        tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_load_byte();
        exp_t e;
        tick();
        drive_req(4'd5, 5'd0, 2'd3, 1'b0);
        sb.push_back('{32'hFFFF_FF80, 1'b1});
        #1;
        checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL ldb stall_req c0: got %b want 1", stall_req); end
        tick();
        req_valid = 1'b0;
        #1;
        checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL ldb stall_req c1: got %b want 1", stall_req); end
        tick();
        dready = 1'b1;
        dout   = 32'h80FF_1234;
        #1;
        checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL ldb stall_req c2: got %b want 1", stall_req); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL ldb early rd_valid: got %b want 0", rd_valid); end
        tick();
        dready = 1'b0;
        dout   = 32'h0;
        #1;
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL ldb stall_req c3: got %b want 0", stall_req); end
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL ldb rd_valid: got %b want 1", rd_valid); end
        if (rd_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++; $display("FAIL ldb scoreboard: got result want none queued");
            end else begin
                e = sb.pop_front();
                checks++; if (rd_data !== e.d) begin errors++; $display("FAIL ldb rd_data: got %h want %h", rd_data, e.d); end
                checks++; if (rd_we !== e.we) begin errors++; $display("FAIL ldb rd_we: got %b want %b", rd_we, e.we); end
            end
        end
        tick();
        #1;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL ldb rd_valid pulse: got %b want 0", rd_valid); end
    endtask

    task automatic test_results();
        vec_t tbl [16];
        exp_t e;
        tbl[0]  = '{4'd5, 5'd7,  2'd2, 1'b0, 32'h8001_7FFF, 1, 32'h0000_8001, 1'b1};
        tbl[1]  = '{4'd5, 5'd1,  2'd0, 1'b0, 32'h8001_7FFF, 2, 32'h0000_7FFF, 1'b1};
        tbl[2]  = '{4'd6, 5'd12, 2'd0, 1'b0, 32'hDEAD_BEEF, 3, 32'h0000_0000, 1'b1};
        tbl[3]  = '{4'd6, 5'd12, 2'd0, 1'b1, 32'hDEAD_BEEF, 4, 32'h0000_0001, 1'b1};
        tbl[4]  = '{4'd5, 5'd5,  2'd0, 1'b0, 32'h1234_5678, 1, 32'h0000_0000, 1'b0};
        tbl[5]  = '{4'd5, 5'd6,  2'd2, 1'b0, 32'h80FF_1234, 2, 32'h0000_00FF, 1'b1};
        tbl[6]  = '{4'd5, 5'd0,  2'd2, 1'b0, 32'h80FF_1234, 3, 32'hFFFF_FFFF, 1'b1};
        tbl[7]  = '{4'd5, 5'd1,  2'd3, 1'b0, 32'h8001_7FFF, 4, 32'hFFFF_8001, 1'b1};
        tbl[8]  = '{4'd5, 5'd7,  2'd1, 1'b0, 32'h8001_7FFF, 1, 32'h0000_7FFF, 1'b1};
        tbl[9]  = '{4'd5, 5'd2,  2'd0, 1'b0, 32'hCAFE_F00D, 2, 32'hCAFE_F00D, 1'b1};
        tbl[10] = '{4'd6, 5'd11, 2'd0, 1'b1, 32'h0BAD_C0DE, 3, 32'h0BAD_C0DE, 1'b1};
        tbl[11] = '{4'd5, 5'd8,  2'd0, 1'b0, 32'hFFFF_FFFF, 4, 32'h0000_0000, 1'b0};
        tbl[12] = '{4'd9, 5'd0,  2'd0, 1'b0, 32'hFFFF_FFFF, 1, 32'h0000_0000, 1'b0};
        tbl[13] = '{4'd5, 5'd3,  2'd1, 1'b0, 32'hFFFF_FFFF, 2, 32'h0000_0000, 1'b0};
        tbl[14] = '{4'd6, 5'd0,  2'd0, 1'b1, 32'hFFFF_FFFF, 3, 32'h0000_0000, 1'b0};
        tbl[15] = '{4'd5, 5'd0,  2'd1, 1'b0, 32'h0000_8000, 4, 32'hFFFF_FF80, 1'b1};
        for (int i = 0; i < 16; i++) begin
            tick();
            drive_req(tbl[i].c, tbl[i].s, tbl[i].a, tbl[i].ll);
            sb.push_back('{tbl[i].ed, tbl[i].ew});
            tick();
            req_valid = 1'b0;
            llbit     = ~tbl[i].ll;
            for (int k = 1; k < tbl[i].lat; k++) tick();
            dready = 1'b1;
            dout   = tbl[i].w;
            tick();
            dready = 1'b0;
            dout   = ~tbl[i].w;
            #1;
            checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL res[%0d] rd_valid: got %b want 1", i, rd_valid); end
            if (rd_valid === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL res[%0d] scoreboard: got result want none queued", i);
                end else begin
                    e = sb.pop_front();
                    checks++; if (rd_data !== e.d) begin errors++; $display("FAIL res[%0d] rd_data: got %h want %h", i, rd_data, e.d); end
                    checks++; if (rd_we !== e.we) begin errors++; $display("FAIL res[%0d] rd_we: got %b want %b", i, rd_we, e.we); end
                end
            end
            tick();
            #1;
            checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL res[%0d] rd_valid pulse: got %b want 0", i, rd_valid); end
        end
    endtask

    task automatic test_flush();
        exp_t e;
        tick();
        drive_req(4'd5, 5'd2, 2'd0, 1'b0);
        #1;
        checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL flush stall_req c0: got %b want 1", stall_req); end
        tick();
        req_valid = 1'b0;
        flush     = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) begin
                dready = 1'b1;
                dout   = 32'hA5A5_A5A5;
            end
            #1;
            checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL flush stall_req c%0d: got %b want 1", c, stall_req); end
            checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL flush rd_valid c%0d: got %b want 0", c, rd_valid); end
            tick();
            flush = 1'b0;
        end
        dready = 1'b0;
        #1;
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL flush stall_req after ready: got %b want 0", stall_req); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL flush dropped rd_valid: got %b want 0", rd_valid); end
        drive_req(4'd5, 5'd2, 2'd0, 1'b0);
        sb.push_back('{32'h1357_9BDF, 1'b1});
        #1;
        checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL flush next req stall_req: got %b want 1", stall_req); end
        tick();
        req_valid = 1'b0;
        dready    = 1'b1;
        dout      = 32'h1357_9BDF;
        tick();
        dready = 1'b0;
        #1;
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL flush next rd_valid: got %b want 1", rd_valid); end
        if (rd_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++; $display("FAIL flush next scoreboard: got result want none queued");
            end else begin
                e = sb.pop_front();
                checks++; if (rd_data !== e.d) begin errors++; $display("FAIL flush next rd_data: got %h want %h", rd_data, e.d); end
            end
        end
        tick();
        drive_req(4'd5, 5'd2, 2'd0, 1'b0);
        flush = 1'b1;
        #1;
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL idle flush stall_req: got %b want 0", stall_req); end
        tick();
        req_valid = 1'b0;
        flush     = 1'b0;
        dready    = 1'b1;
        dout      = 32'h7777_7777;
        #1;
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL idle flush ignored: got stall_req %b want 0", stall_req); end
        tick();
        dready = 1'b0;
        #1;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL idle ready ignored rd_valid: got %b want 0", rd_valid); end
    endtask

    task automatic test_stall_hold();
        exp_t e;
        int   handoffs;
        e.d = 32'h0;
        e.we = 1'b0;
        handoffs = 0;
        tick();
        drive_req(4'd5, 5'd1, 2'd2, 1'b0);
        sb.push_back('{32'hFFFF_9ABC, 1'b1});
        tick();
        req_valid = 1'b0;
        dready    = 1'b1;
        dout      = 32'h9ABC_0000;
        stall     = 1'b1;
        tick();
        dready = 1'b0;
        #1;
        checks++;
        if (sb.size() == 0) begin
            errors++; $display("FAIL stall scoreboard: got result want none queued");
        end else begin
            e = sb.pop_front();
        end
        for (int k = 0; k < 4; k++) begin
            checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL stall rd_valid k%0d: got %b want 1", k, rd_valid); end
            checks++; if (rd_data !== e.d) begin errors++; $display("FAIL stall rd_data k%0d: got %h want %h", k, rd_data, e.d); end
            checks++; if (rd_we !== e.we) begin errors++; $display("FAIL stall rd_we k%0d: got %b want %b", k, rd_we, e.we); end
            checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL stall stall_req k%0d: got %b want 1", k, stall_req); end
            if (rd_valid === 1'b1 && stall === 1'b0) handoffs++;
            dready = (k == 1);
            dout   = 32'h1111_1111;
            tick();
            #1;
        end
        dready = 1'b0;
        stall  = 1'b0;
        #1;
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL stall release rd_valid: got %b want 1", rd_valid); end
        checks++; if (rd_data !== e.d) begin errors++; $display("FAIL stall release rd_data: got %h want %h", rd_data, e.d); end
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL stall release stall_req: got %b want 0", stall_req); end
        if (rd_valid === 1'b1) handoffs++;
        for (int k = 0; k < 2; k++) begin
            tick();
            #1;
            if (rd_valid === 1'b1) handoffs++;
        end
        checks++; if (handoffs != 1) begin errors++; $display("FAIL stall handoffs: got %0d want 1", handoffs); end

        drive_req(4'd5, 5'd2, 2'd0, 1'b0);
        sb.push_back('{32'h2468_ACE0, 1'b1});
        tick();
        req_valid = 1'b0;
        dready    = 1'b1;
        dout      = 32'h2468_ACE0;
        stall     = 1'b1;
        tick();
        dready = 1'b0;
        flush  = 1'b1;
        #1;
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL hold flush rd_valid: got %b want 1", rd_valid); end
        checks++;
        if (sb.size() == 0) begin
            errors++; $display("FAIL hold flush scoreboard: got result want none queued");
        end else begin
            e = sb.pop_front();
            if (rd_data !== e.d) begin errors++; $display("FAIL hold flush rd_data: got %h want %h", rd_data, e.d); end
        end
        tick();
        flush = 1'b0;
        #1;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL hold flush exit rd_valid: got %b want 0", rd_valid); end
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL hold flush exit stall_req: got %b want 0", stall_req); end
        stall = 1'b0;
    endtask

    task automatic test_timeout();
        exp_t e;
        tick();
        drive_req(4'd5, 5'd2, 2'd0, 1'b0);
        sb.push_back('{32'h55AA_33CC, 1'b1});
        tick();
        req_valid = 1'b0;
        for (int k = 0; k < 1022; k++) tick();
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout early: got %b want 0", timeout_err); end
        checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL timeout stall_req: got %b want 1", stall_req); end
        tick();
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout set: got %b want 1", timeout_err); end
        dready = 1'b1;
        dout   = 32'h55AA_33CC;
        tick();
        dready = 1'b0;
        #1;
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL timeout late rd_valid: got %b want 1", rd_valid); end
        if (rd_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++; $display("FAIL timeout scoreboard: got result want none queued");
            end else begin
                e = sb.pop_front();
                checks++; if (rd_data !== e.d) begin errors++; $display("FAIL timeout rd_data: got %h want %h", rd_data, e.d); end
            end
        end
        tick();
        #1;
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout sticky: got %b want 1", timeout_err); end

        drive_req(4'd5, 5'd0, 2'd0, 1'b0);
        tick();
        req_valid = 1'b0;
        tick();
        #2;
        checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL midwait stall_req: got %b want 1", stall_req); end
        rstn = 1'b0;
        #1;
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL async reset stall_req: got %b want 0", stall_req); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL async reset rd_valid: got %b want 0", rd_valid); end
        checks++; if (rd_we !== 1'b0) begin errors++; $display("FAIL async reset rd_we: got %b want 0", rd_we); end
        checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL async reset rd_data: got %h want 0", rd_data); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL async reset timeout_err: got %b want 0", timeout_err); end
        tick();
        rstn = 1'b1;
        tick();
        #1;
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL post reset idle stall_req: got %b want 0", stall_req); end
    endtask

    initial begin
        test_reset();
        test_load_byte();
        test_results();
        test_flush();
        test_stall_hold();
        test_timeout();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL scoreboard drain: got %0d pending want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
